// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one uart_tx among NUM_REQ
// byte producers. It grants one requester at a time, issues the DV pulse,
// follows the frame through Active/Done and pulses a one-hot ack when the
// byte has left the line.
// Optional build macro UART_TX_SCHED_HEADER_EN: each grant first sends the
// header byte {5'b10100, ch} and then the data byte, with one ack at the end.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int CH_W    = 3
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_Busy,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done
);

  localparam int NCH = 1 << CH_W;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] ISSUE       = 3'd1;
  localparam logic [2:0] WAIT_ACTIVE = 3'd2;
  localparam logic [2:0] WAIT_DONE   = 3'd3;
  localparam logic [2:0] WAIT_CLR    = 3'd4;

  logic [2:0]       state;
  logic [CH_W-1:0]  cur_ch, last_ch, win_ch, cand;
  logic             win_vld;
  logic [7:0]       data_q;
  logic [7:0]       grant_byte;
  logic [7:0]       sel_byte;

  // Pad request/byte vectors out to the full channel-index range so a CH_W
  // wide index selects them without width games.
  logic [NCH-1:0]   req_pad;
  logic [8*NCH-1:0] byte_pad;
  logic [NCH-1:0]   ack_vec;

  assign req_pad  = NCH'(i_Req);
  assign byte_pad = (8*NCH)'(i_Req_Byte);
  assign ack_vec  = NCH'(1) << cur_ch;
  assign sel_byte = byte_pad[{win_ch, 3'b000} +: 8];

`ifdef UART_TX_SCHED_HEADER_EN
  logic hdr_pend;  // data byte still owed after the header frame
  assign grant_byte = {5'b10100, win_ch};
`else
  assign grant_byte = sel_byte;
`endif

  // Round-robin search: first requester walking upward from last_ch+1, wrapping at NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_ch  = last_ch;
    cand    = last_ch;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == CH_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_vld && req_pad[cand]) begin
        win_vld = 1'b1;
        win_ch  = cand;
      end
    end
  end

  // Scheduler FSM; DV and the byte are registered on entry to ISSUE so they are valid during it.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= IDLE;
      cur_ch    <= '0;
      last_ch   <= CH_W'(NUM_REQ - 1);
      data_q    <= 8'h00;
      o_Req_Ack <= '0;
      o_Busy    <= 1'b0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
`ifdef UART_TX_SCHED_HEADER_EN
      hdr_pend  <= 1'b0;
`endif
    end else begin
      o_Tx_DV   <= 1'b0;
      o_Req_Ack <= '0;
      case (state)
        IDLE: begin
          // Never issue while the transmitter is still finishing a frame
          // (e.g. one left in flight by a reset of this block).
          if (win_vld && !i_Tx_Active && !i_Tx_Done) begin
            cur_ch    <= win_ch;
            last_ch   <= win_ch;
            data_q    <= sel_byte;
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= grant_byte;
            o_Busy    <= 1'b1;
            state     <= ISSUE;
`ifdef UART_TX_SCHED_HEADER_EN
            hdr_pend  <= 1'b1;
`endif
          end
        end
        ISSUE:       state <= WAIT_ACTIVE;
        WAIT_ACTIVE: if (i_Tx_Active) state <= WAIT_DONE;
        WAIT_DONE:   if (i_Tx_Done) state <= WAIT_CLR;
        WAIT_CLR: begin
          if (!i_Tx_Done) begin
`ifdef UART_TX_SCHED_HEADER_EN
            if (hdr_pend) begin
              hdr_pend  <= 1'b0;
              o_Tx_DV   <= 1'b1;
              o_Tx_Byte <= data_q;
              state     <= ISSUE;
            end else
`endif
            begin
              o_Req_Ack <= ack_vec[NUM_REQ-1:0];
              o_Busy    <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          o_Busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a behavioural uart_tx (CLKS_PER_BIT=4), a line
// receiver, and a round-robin reference model over the set of held requests.
module tb_uart_tx_sched;
  localparam int NUM_REQ = 4;
  localparam int CPB     = 4;
  localparam int FRAME   = 10*CPB + 4;  // DV edge to ack edge for one frame
`ifdef UART_TX_SCHED_HEADER_EN
  localparam int NF = 2;
`else
  localparam int NF = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, tx_rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_byte = '0;
  logic [NUM_REQ-1:0]   ack;
  logic busy, dv, tx_active, tx_done, ser;
  logic [7:0] tx_byte;

  int ncmp = 0, nerr = 0, cyc = 0, model_last = NUM_REQ - 1;
  logic [7:0] ack_q[$], raw_ack_q[$], dv_q[$], rx_q[$], exp_ack_q[$], exp_byte_q[$];
  int ack_cyc[$], dv_cyc[$];
  int dv_viol = 0, ack_bad = 0, busy_bad = 0, rx_bad = 0;
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .CH_W(3)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Req(req), .i_Req_Byte(req_byte),
    .o_Req_Ack(ack), .o_Busy(busy), .o_Tx_DV(dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done));

  // Behavioural transmitter: start, 8 data LSB first, stop; Done held 2 cycles.
  int tx_st, tx_cnt, tx_bit;
  logic [7:0] tx_sh;
  always @(posedge clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      tx_st <= 0; tx_cnt <= 0; tx_bit <= 0; tx_sh <= 8'h00;
      ser <= 1'b1; tx_active <= 1'b0; tx_done <= 1'b0;
    end else begin
      case (tx_st)
        0: begin
          ser <= 1'b1; tx_done <= 1'b0;
          if (dv) begin tx_active <= 1'b1; tx_sh <= tx_byte; tx_cnt <= 0; tx_st <= 1; end
        end
        1: begin
          ser <= 1'b0;
          if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
          else begin tx_cnt <= 0; tx_bit <= 0; tx_st <= 2; end
        end
        2: begin
          ser <= tx_sh[tx_bit];
          if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
          else begin
            tx_cnt <= 0;
            if (tx_bit < 7) tx_bit <= tx_bit + 1; else tx_st <= 3;
          end
        end
        3: begin
          ser <= 1'b1;
          if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
          else begin tx_cnt <= 0; tx_done <= 1'b1; tx_active <= 1'b0; tx_st <= 4; end
        end
        default: begin tx_done <= 1'b1; tx_st <= 0; end
      endcase
    end
  end

  // Line receiver: samples each bit mid-cell, checks start and stop levels.
  initial forever begin
    logic [7:0] b;
    logic s0, s1;
    @(negedge clk);
    if (ser === 1'b0) begin
      repeat (CPB/2) @(negedge clk);
      s0 = ser;
      for (int k = 0; k < 8; k++) begin repeat (CPB) @(negedge clk); b[k] = ser; end
      repeat (CPB) @(negedge clk);
      s1 = ser;
      if (s0 !== 1'b0 || s1 !== 1'b1) rx_bad++;
      rx_q.push_back(b);
    end
  end

  // Output monitor: DV bytes, acks, and protocol anomalies.
  always @(negedge clk) begin
    if (dv === 1'b1) begin
      dv_q.push_back(tx_byte); dv_cyc.push_back(cyc);
      if (tx_active !== 1'b0 || tx_done !== 1'b0) dv_viol++;
    end
    if (ack !== '0) begin
      ack_cyc.push_back(cyc); raw_ack_q.push_back(8'(ack));
      if (!$onehot(ack)) ack_bad++;
      for (int i = 0; i < NUM_REQ; i++) if (ack[i]) ack_q.push_back(8'(i));
      if (prev_ack) ack_bad++;
      if (busy !== 1'b0) busy_bad++;
    end
    prev_ack = (ack !== '0);
  end

  function automatic logic [71:0] pack8(input logic [7:0] q[$]);
    logic [71:0] r = '0;
    foreach (q[i]) r[63:0] = {r[55:0], q[i]};
    r[71:64] = 8'(q.size());
    return r;
  endfunction

  task automatic clear_logs;
    ack_q.delete(); raw_ack_q.delete(); dv_q.delete(); rx_q.delete();
    exp_ack_q.delete(); exp_byte_q.delete(); ack_cyc.delete(); dv_cyc.delete();
    dv_viol = 0; ack_bad = 0; busy_bad = 0; rx_bad = 0;
  endtask

  // Reference: held requests are served walking upward from the last grant.
  task automatic model_batch(input logic [3:0] mask, input logic [31:0] bytes);
    int start = model_last;
    for (int j = 1; j <= NUM_REQ; j++) begin
      int c = (start + j) % NUM_REQ;
      if (mask[c]) begin
        exp_ack_q.push_back(8'(c));
`ifdef UART_TX_SCHED_HEADER_EN
        exp_byte_q.push_back(8'hA0 | 8'(c));
`endif
        exp_byte_q.push_back(bytes[8*c +: 8]);
        model_last = c;
      end
    end
  endtask

  // Raise every channel in mask, drop each channel's request on its ack.
  task automatic run_batch(input logic [3:0] mask, input logic [31:0] bytes);
    int budget = NUM_REQ*NF*(FRAME+5) + 100;
    clear_logs();
    model_batch(mask, bytes);
    @(negedge clk);
    req_byte = bytes; req = mask;
    while (req != '0 && budget > 0) begin
      @(negedge clk);
      req = req & ~ack;
      budget--;
    end
    if (req != '0) begin
      ncmp++; nerr++;
      $display("FAIL batch_timeout: still requesting %b, required all acked", req);
      req = '0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    logic any_dv = 0, any_busy = 0, any_ack = 0, any_byte = 0;
    repeat (3) @(negedge clk);
    ncmp++;
    if ({ack, busy, dv, tx_byte} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got ack=%b busy=%b dv=%b byte=%h, required all 0", ack, busy, dv, tx_byte);
    end
    tx_rst_n = 1'b1; rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      any_dv |= (dv !== 1'b0); any_busy |= (busy !== 1'b0);
      any_ack |= (ack !== '0); any_byte |= (tx_byte !== 8'h00);
    end
    ncmp++; if (any_dv)   begin nerr++; $display("FAIL idle_dv: got DV high while idle, required 0"); end
    ncmp++; if (any_busy) begin nerr++; $display("FAIL idle_busy: got busy high while idle, required 0"); end
    ncmp++; if (any_ack)  begin nerr++; $display("FAIL idle_ack: got ack while idle, required 0"); end
    ncmp++; if (any_byte) begin nerr++; $display("FAIL idle_byte: got tx_byte=%h, required 00", tx_byte); end
  endtask

  task automatic test_single;
    int lat;
    run_batch(4'b0010, 32'h0000_5A00);
    ncmp++; if (dv_q.size() != NF) begin nerr++; $display("FAIL single_dv_count: got %0d, required %0d", dv_q.size(), NF); end
    ncmp++; if (pack8(rx_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL single_line: got %h, required %h", pack8(rx_q), pack8(exp_byte_q)); end
    ncmp++; if (rx_bad != 0) begin nerr++; $display("FAIL single_framing: got %0d bad start/stop, required 0", rx_bad); end
    ncmp++;
    if (raw_ack_q.size() != 1 || raw_ack_q[0] !== 8'h02) begin
      nerr++; $display("FAIL single_ack: got %0d acks first=%h, required one ack 0010", raw_ack_q.size(), raw_ack_q.size() ? raw_ack_q[0] : 8'hxx);
    end
    ncmp++; if (ack_bad + busy_bad != 0) begin nerr++; $display("FAIL single_ack_shape: got %0d wide/busy faults, required 0", ack_bad + busy_bad); end
    lat = (ack_cyc.size() > 0 && dv_cyc.size() > 0) ? ack_cyc[0] - dv_cyc[0] : -1;
    ncmp++; if (lat < NF*FRAME - 1 || lat > NF*FRAME + 1) begin nerr++; $display("FAIL single_latency: got %0d cycles, required %0d +-1", lat, NF*FRAME); end
  endtask

  task automatic test_round_robin;
    run_batch(4'b1111, 32'h4433_2211);
    ncmp++; if (pack8(ack_q) !== pack8(exp_ack_q)) begin nerr++; $display("FAIL rr_order: got %h, required %h", pack8(ack_q), pack8(exp_ack_q)); end
    ncmp++; if (pack8(rx_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL rr_line: got %h, required %h", pack8(rx_q), pack8(exp_byte_q)); end
    ncmp++; if (pack8(dv_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL rr_dv_bytes: got %h, required %h", pack8(dv_q), pack8(exp_byte_q)); end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      int gap = ack_cyc[i] - ack_cyc[i-1];
      ncmp++;
      if (gap < NF*FRAME || gap > NF*FRAME + 2) begin nerr++; $display("FAIL b2b_gap: got %0d cycles, required %0d +-1", gap, NF*FRAME + 1); end
    end
    run_batch(4'b1001, 32'h4433_2211);
    ncmp++; if (pack8(ack_q) !== pack8(exp_ack_q)) begin nerr++; $display("FAIL rr_order2: got %h, required %h", pack8(ack_q), pack8(exp_ack_q)); end
    ncmp++; if (dv_violations_total() != 0) begin nerr++; $display("FAIL rr_protocol: got %0d faults, required 0", dv_violations_total()); end
  endtask

  function automatic int dv_violations_total();
    return dv_viol + ack_bad + busy_bad + rx_bad;
  endfunction

  task automatic test_fairness;
    run_batch(4'b1000, 32'hAB00_0000);
    run_batch(4'b1001, 32'h7700_0066);
    ncmp++;
    if (ack_q.size() != 2 || ack_q[0] !== 8'd0) begin
      nerr++; $display("FAIL fair_wrap: got %0d acks first=%h, required ch0 first", ack_q.size(), ack_q.size() ? ack_q[0] : 8'hxx);
    end
    ncmp++; if (pack8(rx_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL fair_line: got %h, required %h", pack8(rx_q), pack8(exp_byte_q)); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      logic [3:0] m = 4'($urandom_range(1, 15));
      logic [31:0] b = $urandom;
      run_batch(m, b);
      ncmp++; if (pack8(ack_q) !== pack8(exp_ack_q)) begin nerr++; $display("FAIL rand_order[%0d] mask=%b: got %h, required %h", r, m, pack8(ack_q), pack8(exp_ack_q)); end
      ncmp++; if (pack8(rx_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL rand_line[%0d]: got %h, required %h", r, pack8(rx_q), pack8(exp_byte_q)); end
      ncmp++; if (dv_violations_total() != 0) begin nerr++; $display("FAIL rand_protocol[%0d]: got %0d faults, required 0", r, dv_violations_total()); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n = 0, budget = 4*NF*(FRAME+5) + 100;
    clear_logs();
    @(negedge clk);
    req_byte = 32'h0096_0000; req = 4'b0100;
    while (dv !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (dv !== 1'b1) begin ncmp++; nerr++; $display("FAIL rst_first_dv: got no DV, required a grant"); end
    repeat (20) @(negedge clk);  // line is now in data bit 3
    rst_n = 1'b0;
    #1;
    ncmp++;
    if ({ack, busy, dv} !== '0) begin nerr++; $display("FAIL rst_clear: got ack=%b busy=%b dv=%b, required 0", ack, busy, dv); end
    @(negedge clk);
    rst_n = 1'b1;
    while (req != '0 && budget > 0) begin @(negedge clk); req = req & ~ack; budget--; end
    if (req != '0) begin ncmp++; nerr++; $display("FAIL rst_timeout: ch2 never acked"); req = '0; end
    repeat (3) @(negedge clk);
    // The aborted frame still completes on the line, then ch2 is served afresh.
`ifdef UART_TX_SCHED_HEADER_EN
    exp_byte_q.push_back(8'hA2);
    exp_byte_q.push_back(8'hA2);
`else
    exp_byte_q.push_back(8'h96);
`endif
    exp_byte_q.push_back(8'h96);
    exp_ack_q.push_back(8'd2);
    model_last = 2;
    ncmp++; if (pack8(ack_q) !== pack8(exp_ack_q)) begin nerr++; $display("FAIL rst_ack: got %h, required %h", pack8(ack_q), pack8(exp_ack_q)); end
    ncmp++; if (pack8(rx_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL rst_line: got %h, required %h", pack8(rx_q), pack8(exp_byte_q)); end
    ncmp++; if (pack8(dv_q) !== pack8(exp_byte_q)) begin nerr++; $display("FAIL rst_dv_bytes: got %h, required %h", pack8(dv_q), pack8(exp_byte_q)); end
    ncmp++; if (dv_viol != 0) begin nerr++; $display("FAIL rst_dv_while_busy: got %0d, required 0", dv_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
